// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe turn sequencer.
package tictactoe_pkg;

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_A    = 2'b01,
    WIN_B    = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  localparam logic [3:0] FULL_BOARD = 4'd9;

  function automatic logic is_onehot9(input logic [8:0] v);
    return (v != '0) && ((v & (v - 9'd1)) == '0);
  endfunction

endpackage

// File: rtl/tictactoe_game_ctrl_detect.sv
// Three-in-a-row detector. Bit order: rows top..bottom, columns left..right,
// then the 8-4-0 and 6-4-2 diagonals. Square 8 is top-left.
module DetectWinner
  import tictactoe_pkg::*;
(
  input  logic [8:0] ain,
  input  logic [8:0] bin,
  output logic [7:0] win_line
);

  function automatic logic [7:0] lines(input logic [8:0] b);
    return {b[6] & b[4] & b[2], b[8] & b[4] & b[0],
            b[6] & b[3] & b[0], b[7] & b[4] & b[1], b[8] & b[5] & b[2],
            b[2] & b[1] & b[0], b[5] & b[4] & b[3], b[8] & b[7] & b[6]};
  endfunction

  assign win_line = lines(ain) | lines(bin);

endmodule

// File: rtl/tictactoe_game_ctrl.sv
// Turn sequencer and referee: owns both boards, accepts one-hot moves over
// valid/ready, rejects illegal ones and declares win, draw or player change.
module tictactoe_game_ctrl
  import tictactoe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       first_b,
  input  logic       move_valid,
  input  logic [8:0] move,
  output logic       move_ready,
  output logic       illegal,
  output logic [8:0] ain,
  output logic [8:0] bin,
  output logic       turn,
  output logic [3:0] move_count,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [7:0] win_line
);

  state_e      state_q, state_d;
  winner_e     winner_q, winner_d;
  logic [8:0]  ain_q, ain_d, bin_q, bin_d;
  logic [3:0]  count_q, count_d;
  logic [7:0]  line_q, line_d;
  logic        turn_q, turn_d;
  logic        mover_q, mover_d;
  logic        illegal_q, illegal_d;
  logic        over_q, over_d;
  logic [8:0]  mover_board;
  logic [7:0]  det_line;
  logic        legal;

  // Only the mover's board can hold a new win, so the detector sees just that one.
  assign mover_board = mover_q ? bin_q : ain_q;

  DetectWinner u_detect (
    .ain      (mover_board),
    .bin      ('0),
    .win_line (det_line)
  );

  assign legal = is_onehot9(move) && ((move & (ain_q | bin_q)) == '0);

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    ain_d     = ain_q;
    bin_d     = bin_q;
    count_d   = count_q;
    line_d    = line_q;
    turn_d    = turn_q;
    mover_d   = mover_q;
    over_d    = over_q;
    illegal_d = 1'b0;
    if (new_game) begin
      ain_d    = '0;
      bin_d    = '0;
      count_d  = '0;
      line_d   = '0;
      winner_d = WIN_NONE;
      over_d   = 1'b0;
      turn_d   = first_b;
      state_d  = first_b ? WAIT_B : WAIT_A;
    end else begin
      unique case (state_q)
        WAIT_A, WAIT_B: begin
          if (move_valid) begin
            if (legal) begin
              if (turn_q) bin_d = bin_q | move;
              else        ain_d = ain_q | move;
              count_d = count_q + 4'd1;
              mover_d = turn_q;
              state_d = CHECK;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        CHECK: begin
          if (det_line != '0) begin
            line_d   = det_line;
            winner_d = mover_q ? WIN_B : WIN_A;
            over_d   = 1'b1;
            state_d  = DONE;
          end else if (count_q == FULL_BOARD) begin
            winner_d = WIN_DRAW;
            over_d   = 1'b1;
            state_d  = DONE;
          end else begin
            turn_d  = ~turn_q;
            state_d = turn_q ? WAIT_A : WAIT_B;
          end
        end
        DONE: ;
        default: state_d = WAIT_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= WAIT_A;
      winner_q  <= WIN_NONE;
      ain_q     <= '0;
      bin_q     <= '0;
      count_q   <= '0;
      line_q    <= '0;
      turn_q    <= 1'b0;
      mover_q   <= 1'b0;
      illegal_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      ain_q     <= ain_d;
      bin_q     <= bin_d;
      count_q   <= count_d;
      line_q    <= line_d;
      turn_q    <= turn_d;
      mover_q   <= mover_d;
      illegal_q <= illegal_d;
      over_q    <= over_d;
    end
  end

  assign move_ready = (state_q == WAIT_A) || (state_q == WAIT_B);
  assign illegal    = illegal_q;
  assign ain        = ain_q;
  assign bin        = bin_q;
  assign turn       = turn_q;
  assign move_count = count_q;
  assign game_over  = over_q;
  assign winner     = winner_q;
  assign win_line   = line_q;

endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// Self-checking bench for tictactoe_game_ctrl: directed game scenarios plus
// random play, compared against a square-ownership reference model.
module tb_tictactoe_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       new_game, first_b, move_valid;
  logic [8:0] move;
  logic       move_ready, illegal, turn, game_over;
  logic [8:0] ain, bin;
  logic [3:0] move_count;
  logic [1:0] winner;
  logic [7:0] win_line;

  int n_checks = 0;
  int n_err    = 0;

  tictactoe_game_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .new_game   (new_game),
    .first_b    (first_b),
    .move_valid (move_valid),
    .move       (move),
    .move_ready (move_ready),
    .illegal    (illegal),
    .ain        (ain),
    .bin        (bin),
    .turn       (turn),
    .move_count (move_count),
    .game_over  (game_over),
    .winner     (winner),
    .win_line   (win_line)
  );

  always #5 clk = ~clk;

  // Reference model: owner per square (0 empty, 1 A, 2 B) and game flags.
  int         owner [9];
  int         m_count;
  bit         m_turn, m_busy, m_done, m_illegal, m_mover;
  logic [1:0] m_winner;
  logic [7:0] m_line;
  int         lines [8][3] = '{'{8,7,6}, '{5,4,3}, '{2,1,0}, '{8,5,2},
                               '{7,4,1}, '{6,3,0}, '{8,4,0}, '{6,4,2}};

  function automatic logic [8:0] board_of(input int p);
    logic [8:0] b = '0;
    for (int i = 0; i < 9; i++) if (owner[i] == p) b[i] = 1'b1;
    return b;
  endfunction

  function automatic logic [7:0] lines_of(input int p);
    logic [7:0] w = '0;
    for (int l = 0; l < 8; l++)
      if (owner[lines[l][0]] == p && owner[lines[l][1]] == p && owner[lines[l][2]] == p)
        w[l] = 1'b1;
    return w;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 9; i++) owner[i] = 0;
    m_count = 0; m_turn = 0; m_busy = 0; m_done = 0; m_illegal = 0; m_mover = 0;
    m_winner = 2'b00; m_line = '0;
  endtask

  task automatic mdl_step(input logic ng, input logic fb, input logic mv, input logic [8:0] m);
    int ones, idx;
    logic [7:0] wl;
    m_illegal = 0;
    if (ng) begin
      for (int i = 0; i < 9; i++) owner[i] = 0;
      m_count = 0; m_winner = 2'b00; m_line = '0;
      m_done = 0; m_busy = 0; m_turn = fb;
    end else if (m_busy) begin
      m_busy = 0;
      wl = lines_of(m_mover ? 2 : 1);
      if (wl != 0) begin
        m_line = wl; m_winner = m_mover ? 2'b10 : 2'b01; m_done = 1;
      end else if (m_count == 9) begin
        m_winner = 2'b11; m_done = 1;
      end else begin
        m_turn = !m_turn;
      end
    end else if (!m_done && mv) begin
      ones = 0; idx = 0;
      for (int i = 0; i < 9; i++) if (m[i]) begin ones++; idx = i; end
      if (ones == 1 && owner[idx] == 0) begin
        owner[idx] = m_turn ? 2 : 1;
        m_count++;
        m_mover = m_turn;
        m_busy = 1;
      end else begin
        m_illegal = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("move_ready", move_ready, !(m_busy || m_done));
    check("illegal",    illegal,    m_illegal);
    check("ain",        ain,        board_of(1));
    check("bin",        bin,        board_of(2));
    check("turn",       turn,       m_turn);
    check("move_count", move_count, m_count);
    check("game_over",  game_over,  m_done);
    check("winner",     winner,     m_winner);
    check("win_line",   win_line,   m_line);
  endtask

  task automatic cyc(input logic ng, input logic fb, input logic mv, input logic [8:0] m);
    new_game = ng; first_b = fb; move_valid = mv; move = m;
    @(posedge clk);
    mdl_step(ng, fb, mv, m);
    #1;
    check_all();
  endtask

  task automatic play(input logic [8:0] m);
    cyc(1'b0, 1'b0, 1'b1, m);
    cyc(1'b0, 1'b0, 1'b0, '0);
  endtask

  logic [8:0] row_seq  [5] = '{9'h100, 9'h008, 9'h080, 9'h004, 9'h040};
  logic [8:0] draw_seq [9] = '{9'h100, 9'h080, 9'h040, 9'h010, 9'h020,
                               9'h004, 9'h008, 9'h001, 9'h002};
  logic [8:0] hs_seq   [6] = '{9'h100, 9'h002, 9'h001, 9'h004, 9'h010, 9'h020};

  initial begin
    reset = 1'b1; new_game = 1'b0; first_b = 1'b0; move_valid = 1'b0; move = '0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Row win for A
    foreach (row_seq[i]) play(row_seq[i]);
    check("row_winner", winner, 2'b01);
    check("row_line", win_line, 8'h01);
    check("row_over", game_over, 1'b1);
    check("row_count", move_count, 4'd5);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 9'h001);
    check("done_no_illegal", illegal, 1'b0);

    // Illegal moves by B
    cyc(1'b1, 1'b0, 1'b0, '0);
    play(9'h010);
    cyc(1'b0, 1'b0, 1'b1, 9'h010);
    check("occupied_illegal", illegal, 1'b1);
    check("occupied_turn", turn, 1'b1);
    check("occupied_bin", bin, 9'h000);
    cyc(1'b0, 1'b0, 1'b1, 9'h003);
    check("not_onehot_illegal", illegal, 1'b1);
    play(9'h001);

    // Asynchronous reset mid-game
    cyc(1'b1, 1'b0, 1'b0, '0);
    play(9'h100);
    play(9'h001);
    play(9'h080);
    reset = 1'b1;
    #2;
    mdl_reset();
    check_all();
    check("reset_ain", ain, 9'h000);
    #1 reset = 1'b0;

    // Draw
    foreach (draw_seq[i]) play(draw_seq[i]);
    check("draw_winner", winner, 2'b11);
    check("draw_line", win_line, 8'h00);
    check("draw_count", move_count, 4'd9);

    // Valid held high: one transfer every second cycle
    cyc(1'b1, 1'b0, 1'b0, '0);
    foreach (hs_seq[i]) cyc(1'b0, 1'b0, 1'b1, hs_seq[i]);
    check("hs_count", move_count, 4'd3);

    // new_game with simultaneous move, B first
    cyc(1'b1, 1'b1, 1'b1, 9'h100);
    check("ng_ain", ain, 9'h000);
    check("ng_turn", turn, 1'b1);
    check("ng_ready", move_ready, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 9'h100);
    check("ng_b_moves", bin, 9'h100);
    cyc(1'b0, 1'b0, 1'b0, '0);

    // Random play
    for (int n = 0; n < 3000; n++) begin
      logic       ng, mv;
      logic [8:0] m;
      ng = ($urandom_range(0, 99) < 3) || (m_done && $urandom_range(0, 9) < 3);
      mv = $urandom_range(0, 9) < 7;
      if ($urandom_range(0, 9) == 0) m = 9'($urandom);
      else m = 9'h001 << $urandom_range(0, 8);
      cyc(ng, 1'($urandom), mv, m);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
